// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, requester
// port ids and the arbitration state encoding.
package dmem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        P0_PRI = 1'b0,
        P1_PRI = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_rr_grant.sv
// Per-cycle grant logic for the two memory requesters: CPU port has priority
// unless the debug port has been denied long enough to be promoted.
module dmem_rr_grant
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant0,
    output logic grant1
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic [3:0] cnt_next;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state == P1_PRI) begin
                grant1 = req1_valid;
                grant0 = req0_valid & ~req1_valid;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid & ~req0_valid;
            end
        end
    end

    // The promotion decision uses the updated count so that port 1 wins in the
    // cycle right after its STARVE_LIMIT-th denial.
    always_comb begin
        cnt_next = 4'd0;
        if (req1_valid && !grant1) begin
            cnt_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= P0_PRI;
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= cnt_next;
            case (state)
                P0_PRI: begin
                    if (cnt_next >= LIMIT) begin
                        state <= P1_PRI;
                    end
                end
                P1_PRI: begin
                    if (grant1 || !req1_valid) begin
                        state <= P0_PRI;
                    end
                end
                default: state <= P0_PRI;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: one registered
// command stage, registered per-port responses with a fixed latency of 2.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic grant0;
    logic grant1;

    logic              cmd_valid;
    logic              cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    dmem_rr_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Address and data are zeroed when idle so the memory bus is quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_port  <= PORT_CPU;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            cmd_valid <= grant0 | grant1;
            if (grant1) begin
                cmd_port  <= PORT_DBG;
                cmd_we    <= req1_we;
                cmd_addr  <= req1_addr;
                cmd_wdata <= req1_wdata;
            end else if (grant0) begin
                cmd_port  <= PORT_CPU;
                cmd_we    <= req0_we;
                cmd_addr  <= req0_addr;
                cmd_wdata <= req0_wdata;
            end else begin
                cmd_port  <= PORT_CPU;
                cmd_we    <= 1'b0;
                cmd_addr  <= '0;
                cmd_wdata <= '0;
            end
        end
    end

    // A command caught by reset must never reach the memory as a write.
    assign mem_read       = cmd_valid & ~cmd_we;
    assign mem_write      = cmd_valid & cmd_we & ~rst;
    assign mem_address    = cmd_addr;
    assign mem_write_data = cmd_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= cmd_valid && (cmd_port == PORT_CPU);
            rsp1_valid <= cmd_valid && (cmd_port == PORT_DBG);
            if (cmd_valid && cmd_port == PORT_CPU) begin
                rsp0_rdata <= cmd_we ? '0 : mem_read_data;
            end
            if (cmd_valid && cmd_port == PORT_DBG) begin
                rsp1_rdata <= cmd_we ? '0 : mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word behavioural memory behind it.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    logic [DATA_W-1:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_we        (req0_we),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .rsp0_valid     (rsp0_valid),
        .rsp0_rdata     (rsp0_rdata),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_we        (req1_we),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .rsp1_valid     (rsp1_valid),
        .rsp1_rdata     (rsp1_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[7:0]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[7:0]] <= mem_write_data;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic drive0(input logic we, input logic [31:0] addr, input logic [31:0] data);
        req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = data;
    endtask

    task automatic drive1(input logic we, input logic [31:0] addr, input logic [31:0] data);
        req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = data;
    endtask

    function automatic logic [31:0] bb_data(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b1, 32'h5, 32'h5);
        drive1(1'b1, 32'h6, 32'h6);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
            end
        end
        checks++;
        if ({rsp0_valid, rsp1_valid, mem_read, mem_write, rsp0_rdata, rsp1_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b %b %b %b %h %h expected all zero",
                     rsp0_valid, rsp1_valid, mem_read, mem_write, rsp0_rdata, rsp1_rdata);
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_read, mem_write, rsp0_valid, rsp1_valid, req0_ready, req1_ready,
                 mem_address, mem_write_data} !== '0) begin
                errors++;
                $display("[TB] FAIL idle_quiet cycle %0d: rd=%b wr=%b rsp=%b%b rdy=%b%b addr=%h wd=%h expected all zero",
                         i, mem_read, mem_write, rsp0_valid, rsp1_valid, req0_ready, req1_ready,
                         mem_address, mem_write_data);
            end
            next_cycle();
        end
    endtask

    task automatic test_p0_write_read();
        drive0(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL p0_wr_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        next_cycle();
        drive0(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if ({req0_ready, mem_write, mem_read, mem_address, mem_write_data} !==
            {1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL p0_wr_mem: rdy=%b wr=%b rd=%b addr=%h wd=%h expected 1 1 0 00000010 deadbeef",
                     req0_ready, mem_write, mem_read, mem_address, mem_write_data);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_rdata, mem_read} !== {2'b10, 32'h0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL p0_wr_ack: rsp=%b%b rdata=%h rd=%b expected 10 00000000 1",
                     rsp0_valid, rsp1_valid, rsp0_rdata, mem_read);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL p0_rd_data: rsp=%b%b rdata=%h expected 10 deadbeef",
                     rsp0_valid, rsp1_valid, rsp0_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL p0_rsp_pulse: got %b expected 0", rsp0_valid);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        int denied;
        int max_denied;
        logic [1:0] exp_rdy;
        denied = 0;
        max_denied = 0;
        drive0(1'b0, 32'h40, 32'h0);
        drive1(1'b0, 32'h41, 32'h0);
        for (int k = 0; k < 15; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            exp_rdy = ((k % 5) == 4) ? 2'b01 : 2'b10;
            checks++;
            if ({req0_ready, req1_ready} !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL starve_grant cycle %0d: got %b expected %b",
                         k, {req0_ready, req1_ready}, exp_rdy);
            end
            if (req1_ready === 1'b1) denied = 0;
            else denied++;
            if (denied > max_denied) max_denied = denied;
        end
        checks++;
        if (max_denied + 1 > 5) begin
            errors++;
            $display("[TB] FAIL starve_wait: got %0d cycles expected at most 5", max_denied + 1);
        end
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_p1_write();
        drive1(1'b1, 32'h20, 32'h0000_00AA);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL p1_wr_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        next_cycle();
        idle_inputs();
        drive0(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checks++;
        if ({req0_ready, mem_write, mem_address, mem_write_data} !== {2'b11, 32'h20, 32'hAA}) begin
            errors++;
            $display("[TB] FAIL p1_wr_mem: rdy=%b wr=%b addr=%h wd=%h expected 1 1 00000020 000000aa",
                     req0_ready, mem_write, mem_address, mem_write_data);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp1_rdata} !== {2'b01, 32'h0}) begin
            errors++;
            $display("[TB] FAIL p1_wr_ack: rsp=%b%b rdata1=%h expected 01 00000000",
                     rsp0_valid, rsp1_valid, rsp1_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 32'hAA}) begin
            errors++;
            $display("[TB] FAIL p1_then_p0_read: rsp=%b%b rdata0=%h expected 10 000000aa",
                     rsp0_valid, rsp1_valid, rsp0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int i = 0; i < 8; i++) begin
            drive1(1'b1, 32'(i), bb_data(i));
            @(negedge clk);
            checks++;
            if (req1_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_wr_ready %0d: got %b expected 1", i, req1_ready);
            end
            next_cycle();
        end
        idle_inputs();
        repeat (2) next_cycle();
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) drive0(1'b0, 32'(k), 32'h0);
            else idle_inputs();
            @(negedge clk);
            exp_v = (k >= 2 && k < 10);
            checks++;
            if ({req0_ready, rsp0_valid} !== {(k < 8) ? 1'b1 : 1'b0, exp_v}) begin
                errors++;
                $display("[TB] FAIL b2b_rd_handshake %0d: rdy=%b rsp0=%b expected %b %b",
                         k, req0_ready, rsp0_valid, (k < 8), exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rsp0_rdata !== bb_data(k - 2)) begin
                    errors++;
                    $display("[TB] FAIL b2b_rd_data %0d: got %h expected %h",
                             k - 2, rsp0_rdata, bb_data(k - 2));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        drive0(1'b1, 32'h30, 32'h1234_5678);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_preload_ready: got %b expected 1", req0_ready);
        end
        next_cycle();
        idle_inputs();
        repeat (2) next_cycle();
        // Four straight port-0 wins leave the FSM in P1_PRI just before reset.
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive0(1'b0, 32'h31, 32'h0);
            else drive0(1'b1, 32'h30, 32'hBAD0_BAD0);
            drive1(1'b0, 32'h32, 32'h0);
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL mid_setup_grant %0d: got %b expected 10", k, {req0_ready, req1_ready});
            end
            next_cycle();
        end
        rst = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, mem_write} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_reset_cycle: rdy=%b%b wr=%b expected 00 0",
                     req0_ready, req1_ready, mem_write);
        end
        next_cycle();
        rst = 1'b0;
        drive0(1'b0, 32'h33, 32'h0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, mem_write, rsp0_valid, rsp1_valid} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL mid_after_reset: rdy=%b%b wr=%b rsp=%b%b expected 10 0 00",
                     req0_ready, req1_ready, mem_write, rsp0_valid, rsp1_valid);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({mem_write, rsp1_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_no_stale: wr=%b rsp1=%b expected 0 0", mem_write, rsp1_valid);
        end
        repeat (3) next_cycle();
        drive0(1'b0, 32'h30, 32'h0);
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL mid_mem_unchanged: rsp0=%b rdata=%h expected 1 12345678",
                     rsp0_valid, rsp0_rdata);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_p0_write_read();
        test_starvation();
        test_p1_write();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256-word data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- Arbitrates per cycle and registers the winning command into a one-deep command stage that drives the memory.
- Returns read data, or a write acknowledge, through a registered response to the requester that issued it.
- Port 0 has priority; a starvation guard guarantees port 1 progress.

Parameters:
- ADDR_W, 32, requester/memory address width (memory decodes address[7:0])
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, consecutive cycles port 1 may be valid-but-denied before it is forced to win (range 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  port 0 command present
- req0_ready  out  1  port 0 command accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  word address
- req0_wdata  in  DATA_W  write data
- rsp0_valid  out  1  response for port 0 (one-cycle pulse)
- rsp0_rdata  out  DATA_W  read data (0 for write acks)
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0
- mem_read  out  1  to data memory read enable
- mem_write  out  1  to data memory write enable
- mem_address  out  ADDR_W  to data memory address
- mem_write_data  out  DATA_W  to data memory write data
- mem_read_data  in  DATA_W  from data memory, combinational read

Behaviour:
- Reset (rst=1 at clk edge): cmd_valid=0, rsp0_valid=rsp1_valid=0, rsp*_rdata=0, starve_cnt=0, arbitration state=P0_PRI. While cmd_valid=0: mem_read=mem_write=0, mem_address=0, mem_write_data=0.
- Handshake: a transfer occurs when reqN_valid and reqN_ready are both 1 at the clock edge. reqN_ready is combinational from valids and arbitration state only. At most one ready is high per cycle. No ready is high while rst=1. Requesters hold their command stable until accepted.
- Arbitration FSM:
  - P0_PRI: grant port 0 if req0_valid, else port 1 if req1_valid.
  - P1_PRI: grant port 1 if req1_valid, else port 0.
  - starve_cnt: increments when req1_valid=1 and port 1 is not granted. Clears when port 1 is granted or req1_valid=0.
  - P0_PRI -> P1_PRI when starve_cnt reaches STARVE_LIMIT.
  - P1_PRI -> P0_PRI after a port-1 grant, or when req1_valid=0.
- Command stage, accepted in cycle N:
  - Registers cmd_valid, cmd_port, cmd_we, cmd_addr, cmd_wdata.
  - Cycle N+1 drives the memory: mem_read = cmd_valid & ~cmd_we; mem_write = cmd_valid & cmd_we; mem_address = cmd_addr; mem_write_data = cmd_wdata.
  - A new grant may be accepted every cycle (fully pipelined, throughput 1/cycle).
- Response: at the end of cycle N+1, rsp{cmd_port}_valid<=1 and rsp_rdata<=mem_read_data for reads, 0 for writes. The response is visible in cycle N+2; fixed latency 2. The other port's rsp_valid<=0. There is no response back-pressure.
- Ordering: a write granted in N commits at the end of N+1. A read granted in N+1 from either port returns the new value.
- Simultaneous valids: one port is granted per the FSM. The loser's ready=0 and it keeps its command.
- Address wrap: addresses are passed through unmodified; wrap above 255 is the memory's behaviour.
- Reset mid-operation:
  - The in-flight command is dropped; mem_write is forced to 0 in the reset cycle and the next cycle.
  - A pending response is cancelled.
  - The FSM returns to P0_PRI.

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W defaults; port-id constants PORT_CPU=0, PORT_DBG=1; arbitration state encoding (P0_PRI, P1_PRI).
- One natural sub-module, dmem_rr_grant: grant logic plus starve_cnt and FSM, producing grant0/grant1.
- The command and response registers stay in dmem_arbiter.

Test Plan:
- Reset then idle: all outputs 0; mem_read=mem_write=0 for 5 cycles.
- Port 0 writes 0xDEADBEEF to addr 0x10 in cycle 1, then reads 0x10 in cycle 2 -> rsp0_valid pulse in cycle 3 (rdata 0) and cycle 4 (rdata 0xDEADBEEF).
- Both ports valid continuously with STARVE_LIMIT=4 -> port 0 wins 4 cycles, port 1 wins the 5th; the pattern repeats; no port-1 wait exceeds 5 cycles.
- Port 1 writes 0x0000_00AA to addr 0x20 while port 0 idle -> accepted the same cycle; port 0 read of 0x20 next cycle returns 0xAA on rsp0 two cycles later.
- Back-to-back reads from port 0 to addrs 0..7 -> one rsp0_valid per cycle, data in order, latency exactly 2.
- rst asserted the cycle after a write to addr 0x30 is accepted -> mem_write stays 0, memory[0x30] unchanged, no rsp pulse, FSM back in P0_PRI.
